// File: rtl/pc_fetch_if.sv
// Instruction-memory fetch port between the fetch sequencer (master) and the memory (slave).
interface pc_fetch_if;
    logic        owImemReq;
    logic [31:0] owImemAddr;
    logic        iwImemAck;
    logic [31:0] iwImemData;

    modport master (output owImemReq, output owImemAddr, input iwImemAck, input iwImemData);
    modport slave  (input owImemReq, input owImemAddr, output iwImemAck, output iwImemData);
endinterface

// File: rtl/pc_fetch_seq.sv
// Fetch sequencer: ADV -> REQ -> VALID loop with trap/branch redirect and ack timeout.
// Optional PC_FETCH_ALIGN_CHECK_EN turns misaligned redirect targets into traps and adds owMisalign.
module pc_fetch_seq #(
    parameter logic [31:0] pTrapVector = 32'h0000_0004,
    parameter int unsigned pAckTimeout = 8
) (
    input  logic        iwClk,
    input  logic        iwRst,
    input  logic [31:0] iwPc,
    output logic        owPcUpdate,
    output logic [31:0] owNextPc,
    pc_fetch_if.master  imem,
    output logic        owInstrValid,
    output logic [31:0] orInstr,
    input  logic        iwDecodeReady,
    input  logic        iwBranchTaken,
    input  logic [31:0] iwBranchTarget,
    input  logic        iwTrap,
    output logic [31:0] orEpc,
`ifdef PC_FETCH_ALIGN_CHECK_EN
    output logic        owMisalign,
`endif
    output logic        orFetchFault
);

    localparam int unsigned CntW = (pAckTimeout > 1) ? $clog2(pAckTimeout) + 1 : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'((pAckTimeout == 0) ? 0 : pAckTimeout - 1);

    typedef enum logic [1:0] {S_START, S_ADV, S_REQ, S_VALID} state_t;

    state_t            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              pend_q, pend_d;
    logic              pend_trap_q, pend_trap_d;
    logic [31:0]       pend_tgt_q, pend_tgt_d;
    logic [31:0]       instr_q, instr_d;
    logic [31:0]       epc_q, epc_d;
    logic              fault_q, fault_d;
    logic              upd_q, req_q, vld_q;
    logic              miss_d;

    logic              arrive, arr_is_trap, take_arrival, redir_now, timeout;
    logic [31:0]       raw_tgt, arr_tgt, merged_tgt;
    logic              merged_trap;

    assign raw_tgt = iwTrap ? pTrapVector : iwBranchTarget;
    assign arrive  = (iwTrap | iwBranchTaken) && (state_q != S_START);

`ifdef PC_FETCH_ALIGN_CHECK_EN
    logic misalign;
    logic misalign_q;
    assign misalign    = arrive && (raw_tgt[1:0] != 2'b00);
    assign arr_tgt     = misalign ? pTrapVector : raw_tgt;
    assign arr_is_trap = iwTrap | misalign;
    assign owMisalign  = misalign_q;
`else
    assign arr_tgt     = raw_tgt;
    assign arr_is_trap = iwTrap;
`endif

    // A pending trap is only displaced by another trap; branches always replace branches.
    assign take_arrival = arrive && !(pend_q && pend_trap_q && !arr_is_trap);
    assign merged_tgt   = take_arrival ? arr_tgt : pend_tgt_q;
    assign merged_trap  = take_arrival ? arr_is_trap : pend_trap_q;
    assign redir_now    = pend_q | arrive;
    assign timeout      = (pAckTimeout != 0) && !imem.iwImemAck && (cnt_q == LastCnt);

    assign owNextPc        = redir_now ? merged_tgt : iwPc + 32'd4;
    assign owPcUpdate      = upd_q;
    assign owInstrValid    = vld_q;
    assign orInstr         = instr_q;
    assign orEpc           = epc_q;
    assign orFetchFault    = fault_q;
    assign imem.owImemReq  = req_q;
    assign imem.owImemAddr = iwPc;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pend_d      = pend_q;
        pend_trap_d = pend_trap_q;
        pend_tgt_d  = pend_tgt_q;
        instr_d     = instr_q;
        epc_d       = epc_q;
        fault_d     = fault_q;
        miss_d      = 1'b0;

        if (arrive) begin
            pend_d      = 1'b1;
            pend_tgt_d  = merged_tgt;
            pend_trap_d = merged_trap;
            if (arr_is_trap) epc_d = iwPc;
`ifdef PC_FETCH_ALIGN_CHECK_EN
            miss_d      = misalign;
`endif
        end

        case (state_q)
            S_START: state_d = S_ADV;
            S_ADV: begin
                pend_d      = 1'b0;
                pend_trap_d = 1'b0;
                cnt_d       = '0;
                state_d     = S_REQ;
            end
            S_REQ: begin
                cnt_d = cnt_q + CntW'(1);
                if (imem.iwImemAck) begin
                    // Wrong-path data is dropped; the redirect is consumed in ADV.
                    if (redir_now) begin
                        state_d = S_ADV;
                    end else begin
                        instr_d = imem.iwImemData;
                        state_d = S_VALID;
                    end
                end else if (timeout) begin
                    fault_d     = 1'b1;
                    pend_d      = 1'b1;
                    pend_trap_d = 1'b1;
                    pend_tgt_d  = pTrapVector;
                    epc_d       = iwPc;
                    state_d     = S_ADV;
                end
            end
            S_VALID: begin
                if (redir_now || iwDecodeReady) state_d = S_ADV;
            end
            default: state_d = S_START;
        endcase
    end

    always_ff @(posedge iwClk or posedge iwRst) begin
        if (iwRst) begin
            state_q     <= S_START;
            cnt_q       <= '0;
            pend_q      <= 1'b0;
            pend_trap_q <= 1'b0;
            pend_tgt_q  <= '0;
            instr_q     <= '0;
            epc_q       <= '0;
            fault_q     <= 1'b0;
            upd_q       <= 1'b0;
            req_q       <= 1'b0;
            vld_q       <= 1'b0;
`ifdef PC_FETCH_ALIGN_CHECK_EN
            misalign_q  <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pend_q      <= pend_d;
            pend_trap_q <= pend_trap_d;
            pend_tgt_q  <= pend_tgt_d;
            instr_q     <= instr_d;
            epc_q       <= epc_d;
            fault_q     <= fault_d;
            upd_q       <= (state_d == S_ADV);
            req_q       <= (state_d == S_REQ);
            vld_q       <= (state_d == S_VALID);
`ifdef PC_FETCH_ALIGN_CHECK_EN
            misalign_q  <= miss_d;
`endif
        end
    end

`ifndef PC_FETCH_ALIGN_CHECK_EN
    logic unused_miss;
    assign unused_miss = miss_d;
`endif

endmodule

// File: tb/tb_pc_fetch_seq.sv
// Directed table-driven bench for pc_fetch_seq plus hand sequences for reset and alignment.
module tb_pc_fetch_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pc = 32'hFFFF_FFFC;
    logic        rdy = 1'b0, br = 1'b0, trap = 1'b0;
    logic [31:0] tgt = '0;
    logic        upd, vld, fault;
    logic [31:0] npc, instr, epc;
`ifdef PC_FETCH_ALIGN_CHECK_EN
    logic        miss;
`endif

    int n_vec = 0;
    int n_bad = 0;

    pc_fetch_if imem ();

    pc_fetch_seq #(.pTrapVector(32'h4), .pAckTimeout(8)) dut (
        .iwClk(clk), .iwRst(rst), .iwPc(pc),
        .owPcUpdate(upd), .owNextPc(npc),
        .imem(imem),
        .owInstrValid(vld), .orInstr(instr),
        .iwDecodeReady(rdy), .iwBranchTaken(br), .iwBranchTarget(tgt), .iwTrap(trap),
        .orEpc(epc),
`ifdef PC_FETCH_ALIGN_CHECK_EN
        .owMisalign(miss),
`endif
        .orFetchFault(fault)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;   logic ack; logic [31:0] data; logic rdy;
        logic br; logic [31:0] tgt; logic trap;
        logic e_upd; logic [31:0] e_npc; logic e_req; logic e_vld;
        logic [31:0] e_instr; logic [31:0] e_epc; logic e_fault;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic [31:0] p, logic a, logic [31:0] d, logic r, logic b,
                                logic [31:0] t, logic tr, logic eu, logic [31:0] en, logic eq,
                                logic ev, logic [31:0] ei, logic [31:0] ee, logic ef);
        vec_t v;
        v.pc = p; v.ack = a; v.data = d; v.rdy = r; v.br = b; v.tgt = t; v.trap = tr;
        v.e_upd = eu; v.e_npc = en; v.e_req = eq; v.e_vld = ev;
        v.e_instr = ei; v.e_epc = ee; v.e_fault = ef;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        pc = v.pc; imem.iwImemAck = v.ack; imem.iwImemData = v.data; rdy = v.rdy;
        br = v.br; tgt = v.tgt; trap = v.trap;
    endtask

    task automatic check(input string name, input vec_t v);
        logic ok;
        ok = (upd === v.e_upd) && (!v.e_upd || npc === v.e_npc) &&
             (imem.owImemReq === v.e_req) && (!v.e_req || imem.owImemAddr === v.pc) &&
             (vld === v.e_vld) && (instr === v.e_instr) && (epc === v.e_epc) &&
             (fault === v.e_fault);
        n_vec++;
        if (!ok) begin
            n_bad++;
            $display("FAIL %s: got upd=%0b npc=%h req=%0b addr=%h vld=%0b instr=%h epc=%h fault=%0b; want upd=%0b npc=%h req=%0b addr=%h vld=%0b instr=%h epc=%h fault=%0b",
                     name, upd, npc, imem.owImemReq, imem.owImemAddr, vld, instr, epc, fault,
                     v.e_upd, v.e_npc, v.e_req, v.pc, v.e_vld, v.e_instr, v.e_epc, v.e_fault);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0b want %0b", name, act, exp);
        end
    endtask

    initial begin
        vec_t v;
        logic [31:0] mis_npc, mis_epc;
        imem.iwImemAck = 1'b0;
        imem.iwImemData = '0;

        //        pc            ack data          rdy br tgt          trap | upd npc         req vld instr         epc           fault
        tbl.push_back(mk(32'hFFFF_FFFC,0,32'h0,        0,0,32'h0,      0, 0,32'h0,       0,0,32'h0,        32'h0,     0));
        tbl.push_back(mk(32'hFFFF_FFFC,0,32'h0,        0,0,32'h0,      0, 1,32'h0,       0,0,32'h0,        32'h0,     0));
        tbl.push_back(mk(32'h0,        0,32'h0,        0,0,32'h0,      0, 0,32'h0,       1,0,32'h0,        32'h0,     0));
        tbl.push_back(mk(32'h100,      1,32'hDEAD0001, 0,0,32'h0,      0, 0,32'h0,       1,0,32'h0,        32'h0,     0));
        tbl.push_back(mk(32'h100,      0,32'h0,        1,0,32'h0,      0, 0,32'h0,       0,1,32'hDEAD0001, 32'h0,     0));
        tbl.push_back(mk(32'h100,      0,32'h0,        0,0,32'h0,      0, 1,32'h104,     0,0,32'hDEAD0001, 32'h0,     0));
        tbl.push_back(mk(32'h100,      1,32'h11112222, 0,0,32'h0,      0, 0,32'h0,       1,0,32'hDEAD0001, 32'h0,     0));
        tbl.push_back(mk(32'h100,      0,32'h0,        1,0,32'h0,      0, 0,32'h0,       0,1,32'h11112222, 32'h0,     0));
        tbl.push_back(mk(32'h100,      0,32'h0,        0,0,32'h0,      0, 1,32'h104,     0,0,32'h11112222, 32'h0,     0));
        tbl.push_back(mk(32'h200,      0,32'h0,        0,1,32'h2000,   0, 0,32'h0,       1,0,32'h11112222, 32'h0,     0));
        tbl.push_back(mk(32'h200,      0,32'h0,        0,0,32'h0,      0, 0,32'h0,       1,0,32'h11112222, 32'h0,     0));
        tbl.push_back(mk(32'h200,      1,32'hBAD0BAD0, 0,0,32'h0,      0, 0,32'h0,       1,0,32'h11112222, 32'h0,     0));
        tbl.push_back(mk(32'h200,      0,32'h0,        0,0,32'h0,      0, 1,32'h2000,    0,0,32'h11112222, 32'h0,     0));
        tbl.push_back(mk(32'h2000,     1,32'h33334444, 0,0,32'h0,      0, 0,32'h0,       1,0,32'h11112222, 32'h0,     0));
        tbl.push_back(mk(32'h2000,     0,32'h0,        0,0,32'h0,      0, 0,32'h0,       0,1,32'h33334444, 32'h0,     0));
        tbl.push_back(mk(32'h2000,     0,32'h0,        0,0,32'h0,      0, 0,32'h0,       0,1,32'h33334444, 32'h0,     0));
        tbl.push_back(mk(32'h40,       0,32'h0,        1,1,32'h3000,   1, 0,32'h0,       0,1,32'h33334444, 32'h0,     0));
        tbl.push_back(mk(32'h40,       0,32'h0,        0,0,32'h0,      0, 1,32'h4,       0,0,32'h33334444, 32'h40,    0));
        tbl.push_back(mk(32'h4,        1,32'h55556666, 0,0,32'h0,      0, 0,32'h0,       1,0,32'h33334444, 32'h40,    0));
        tbl.push_back(mk(32'h4,        0,32'h0,        1,0,32'h0,      0, 0,32'h0,       0,1,32'h55556666, 32'h40,    0));
        tbl.push_back(mk(32'h4,        0,32'h0,        0,1,32'h1000,   0, 1,32'h1000,    0,0,32'h55556666, 32'h40,    0));
        tbl.push_back(mk(32'h1000,     0,32'h0,        0,1,32'h7000,   0, 0,32'h0,       1,0,32'h55556666, 32'h40,    0));
        tbl.push_back(mk(32'h1000,     0,32'h0,        0,0,32'h0,      1, 0,32'h0,       1,0,32'h55556666, 32'h40,    0));
        tbl.push_back(mk(32'h1000,     0,32'h0,        0,1,32'h9000,   0, 0,32'h0,       1,0,32'h55556666, 32'h1000,  0));
        tbl.push_back(mk(32'h1000,     1,32'h12345678, 0,0,32'h0,      0, 0,32'h0,       1,0,32'h55556666, 32'h1000,  0));
        tbl.push_back(mk(32'h1000,     0,32'h0,        0,0,32'h0,      0, 1,32'h4,       0,0,32'h55556666, 32'h1000,  0));
        tbl.push_back(mk(32'h4,        1,32'h77778888, 0,0,32'h0,      0, 0,32'h0,       1,0,32'h55556666, 32'h1000,  0));
        tbl.push_back(mk(32'h4,        0,32'h0,        1,0,32'h0,      0, 0,32'h0,       0,1,32'h77778888, 32'h1000,  0));
        tbl.push_back(mk(32'h4,        0,32'h0,        0,0,32'h0,      0, 1,32'h8,       0,0,32'h77778888, 32'h1000,  0));
        for (int k = 0; k < 8; k++)
            tbl.push_back(mk(32'h8,    0,32'h0,        0,0,32'h0,      0, 0,32'h0,       1,0,32'h77778888, 32'h1000,  0));
        tbl.push_back(mk(32'h8,        0,32'h0,        0,0,32'h0,      0, 1,32'h4,       0,0,32'h77778888, 32'h8,     1));
        tbl.push_back(mk(32'h4,        1,32'h9999AAAA, 0,0,32'h0,      0, 0,32'h0,       1,0,32'h77778888, 32'h8,     1));
        tbl.push_back(mk(32'h4,        0,32'h0,        1,0,32'h0,      0, 0,32'h0,       0,1,32'h9999AAAA, 32'h8,     1));
        tbl.push_back(mk(32'h4,        0,32'h0,        0,0,32'h0,      0, 1,32'h8,       0,0,32'h9999AAAA, 32'h8,     1));

        repeat (3) @(negedge clk);
        #1;
        v = mk(32'hFFFF_FFFC,0,0,0,0,0,0, 0,0,0,0,0,0,0);
        check("reset_state", v);

        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < tbl.size(); i++) begin
            if (i != 0) @(negedge clk);
            drive(tbl[i]);
            #1;
            check($sformatf("vec%0d", i), tbl[i]);
        end

        // Asynchronous reset in the middle of a request.
        @(negedge clk);
        v = mk(32'h8,0,0,0,0,0,0, 0,0,1,0,32'h9999AAAA,32'h8,1);
        drive(v);
        #1;
        check("req_before_reset", v);
        #1 rst = 1'b1;
        #1;
        v = mk(32'h8,0,0,0,0,0,0, 0,0,0,0,0,0,0);
        check("async_reset_clears", v);

        // Stale ack after reset must not be captured.
        @(negedge clk);
        rst = 1'b0;
        v = mk(32'hFFFF_FFFC,1,32'hDEADBEEF,0,0,0,0, 0,0,0,0,0,0,0);
        drive(v);
        #1;
        check("start_after_reset", v);
        @(negedge clk);
        v = mk(32'hFFFF_FFFC,1,32'hDEADBEEF,0,0,0,0, 1,32'h0,0,0,0,0,0);
        drive(v);
        #1;
        check("adv_wrap_after_reset", v);
        @(negedge clk);
        v = mk(32'h0,0,0,0,0,0,0, 0,0,1,0,0,0,0);
        drive(v);
        #1;
        check("stale_ack_ignored", v);
        @(negedge clk);
        v = mk(32'h0,1,32'hABCD0000,0,0,0,0, 0,0,1,0,0,0,0);
        drive(v);
        #1;
        check("fetch_after_reset", v);
        @(negedge clk);
        v = mk(32'h0,0,0,1,0,0,0, 0,0,0,1,32'hABCD0000,0,0);
        drive(v);
        #1;
        check("valid_after_reset", v);

        // Misaligned branch target arriving in ADV.
`ifdef PC_FETCH_ALIGN_CHECK_EN
        mis_npc = 32'h4;  mis_epc = 32'h10;
`else
        mis_npc = 32'h1002; mis_epc = 32'h0;
`endif
        @(negedge clk);
        v = mk(32'h10,0,0,0,1,32'h1002,0, 1,mis_npc,0,0,32'hABCD0000,0,0);
        drive(v);
        #1;
        check("misaligned_branch_npc", v);
        @(negedge clk);
        v = mk(32'h10,0,0,0,0,0,0, 0,0,1,0,32'hABCD0000,mis_epc,0);
        drive(v);
        #1;
        check("misaligned_epc", v);
`ifdef PC_FETCH_ALIGN_CHECK_EN
        check_bit("misalign_pulse", miss, 1'b1);
        @(negedge clk);
        #1;
        check_bit("misalign_single_cycle", miss, 1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
